// File: rtl/program_counter_stack_if.sv
// Fetch-stage control/status bundle between the sequencer (master) and the
// program counter with return-address stack (slave).
interface program_counter_stack_if #(
  parameter int WIDTH        = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int STACK_DEPTH  = 8
);
  localparam int CW = $clog2(STACK_DEPTH) + 1;

  logic                           Stall;
  logic [WIDTH-1:0]               LoadValue;
  logic                           LoadEnable;
  logic signed [OFFSET_WIDTH-1:0] Offset;
  logic                           OffsetEnable;
  logic                           Call;
  logic                           Return;
  logic [WIDTH-1:0]               CounterValue;
  logic [CW-1:0]                  StackCount;
  logic                           Overflow;
  logic                           Underflow;

  modport master (
    output Stall, LoadValue, LoadEnable, Offset, OffsetEnable, Call, Return,
    input  CounterValue, StackCount, Overflow, Underflow
  );

  modport slave (
    input  Stall, LoadValue, LoadEnable, Offset, OffsetEnable, Call, Return,
    output CounterValue, StackCount, Overflow, Underflow
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with hardware return-address stack: stall, load, signed
// relative branch, call/return, sticky overflow/underflow flags.
module program_counter_stack #(
  parameter int WIDTH        = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int STACK_DEPTH  = 8
) (
  input logic                     Clock,
  input logic                     Reset,
  program_counter_stack_if.slave  bus
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic              push;
  logic [IW-1:0]     push_idx, pop_idx;
  logic [WIDTH-1:0]  pc_inc;
  logic signed [WIDTH-1:0] off_ext;
  logic              full, empty;

  assign pc_inc   = pc_q + WIDTH'(1);
  assign off_ext  = WIDTH'(bus.Offset);
  assign full     = (cnt_q == CW'(STACK_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_idx = cnt_q[IW-1:0];
  assign pop_idx  = IW'(cnt_q - CW'(1));

  // Priority: Stall > Return > Call > Load > Offset > increment.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!bus.Stall) begin
      if (bus.Return) begin
        if (empty) begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          pc_d  = stack_q[pop_idx];
          cnt_d = cnt_q - CW'(1);
        end
      end else if (bus.Call) begin
        if (full) begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          push  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          pc_d  = bus.LoadValue;
        end
      end else if (bus.LoadEnable) begin
        pc_d = bus.LoadValue;
      end else if (bus.OffsetEnable) begin
        pc_d = pc_q + off_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack entries are never cleared; StackCount alone decides what is live.
  always_ff @(posedge Clock) begin
    if (!Reset && push) stack_q[push_idx] <= pc_inc;
  end

  assign bus.CounterValue = pc_q;
  assign bus.StackCount   = cnt_q;
  assign bus.Overflow     = ovf_q;
  assign bus.Underflow    = unf_q;
endmodule
